// File: rtl/mux_window_feeder.sv
// mux_window_feeder: upstream stage of the sparse-select mux. It holds a sliding
// window of NUMBER_INPUT_MUX samples and replays a stored program of select codes
// over each window, producing one (window_o, sel_mux_o) pair per cycle.
//
// Ports:
//   clk_i, rst_n_i            clock (rising edge), async active-low reset
//   sel_wr_en/addr/data_i     program write port, honoured only in IDLE
//   start_i, stop_i           start a run (samples sel_len_i/stride_i), request stop
//   sel_len_i, stride_i       codes per window, new samples between windows
//   data_valid_i/data_i/data_ready_o   sample input handshake
//   window_o                  window, [0] is the newest sample
//   sel_mux_o, sel_valid_o    current select code and its valid
//   out_ready_i               consumer accepts the pair
//   play_done_o               one-cycle pulse after the last code of a window
//   sel_err_o                 sticky: an out-of-range code was played
//
// Configuration macro: MUX_FEEDER_ZERO_SKIP_EN -- when defined, code-0 entries are
// consumed in one cycle without presenting a valid pair.
module mux_window_feeder #(
  parameter int unsigned I_WIDTH          = 8,
  parameter int unsigned F_WIDTH          = 8,
  parameter int unsigned NUMBER_INPUT_MUX = 8,
  parameter int unsigned SEL_WIDTH_MUX    = 3,
  parameter int unsigned SEL_DEPTH        = 16,
  localparam int unsigned W      = I_WIDTH + F_WIDTH,
  localparam int unsigned ADDR_W = $clog2(SEL_DEPTH),
  localparam int unsigned LEN_W  = $clog2(SEL_DEPTH + 1),
  localparam int unsigned STR_W  = $clog2(NUMBER_INPUT_MUX + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic                                  sel_wr_en_i,
  input  logic [ADDR_W-1:0]                     sel_wr_addr_i,
  input  logic [SEL_WIDTH_MUX-1:0]              sel_wr_data_i,
  input  logic                                  start_i,
  input  logic                                  stop_i,
  input  logic [LEN_W-1:0]                      sel_len_i,
  input  logic [STR_W-1:0]                      stride_i,
  input  logic                                  data_valid_i,
  input  logic signed [W-1:0]                   data_i,
  output logic                                  data_ready_o,
  output logic [NUMBER_INPUT_MUX-1:0][W-1:0]    window_o,
  output logic [SEL_WIDTH_MUX-1:0]              sel_mux_o,
  output logic                                  sel_valid_o,
  input  logic                                  out_ready_i,
  output logic                                  play_done_o,
  output logic                                  sel_err_o
);

  localparam int unsigned CW = SEL_WIDTH_MUX + 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_PLAY} state_e;

  state_e                             state_q, state_d;
  logic [STR_W-1:0]                   need_q, need_d;
  logic [ADDR_W-1:0]                  idx_q, idx_d;
  logic [LEN_W-1:0]                   len_q, len_d;
  logic [STR_W-1:0]                   stride_q, stride_d;
  logic                               stop_q, stop_d;
  logic [NUMBER_INPUT_MUX-1:0][W-1:0] window_q, window_d;
  logic [SEL_WIDTH_MUX-1:0]           sel_mux_q, sel_mux_d;
  logic                               sel_valid_q, sel_valid_d;
  logic                               data_ready_q, data_ready_d;
  logic                               play_done_q, play_done_d;
  logic                               sel_err_q, sel_err_d;

  logic [SEL_WIDTH_MUX-1:0] prog_mem [SEL_DEPTH];
  logic                     prog_we;
  logic                     start_take;
  logic                     finish;
  logic                     step;
  logic                     last;
  logic                     stop_any;

  // Program storage: written in IDLE only, never reset.
  always_ff @(posedge clk_i) begin
    if (prog_we) prog_mem[sel_wr_addr_i] <= sel_wr_data_i;
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      need_q       <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      stride_q     <= '0;
      stop_q       <= 1'b0;
      window_q     <= '0;
      sel_mux_q    <= '0;
      sel_valid_q  <= 1'b0;
      data_ready_q <= 1'b0;
      play_done_q  <= 1'b0;
      sel_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      need_q       <= need_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      stride_q     <= stride_d;
      stop_q       <= stop_d;
      window_q     <= window_d;
      sel_mux_q    <= sel_mux_d;
      sel_valid_q  <= sel_valid_d;
      data_ready_q <= data_ready_d;
      play_done_q  <= play_done_d;
      sel_err_q    <= sel_err_d;
    end
  end

  // Next state, counters and window.
  always_comb begin
    state_d    = state_q;
    need_d     = need_q;
    idx_d      = idx_q;
    len_d      = len_q;
    stride_d   = stride_q;
    stop_d     = stop_q;
    window_d   = window_q;
    prog_we    = 1'b0;
    start_take = 1'b0;
    finish     = 1'b0;
    stop_any   = stop_q | stop_i;
    // An invalid PLAY cycle (len 0 or a skipped zero code) always advances.
    step       = sel_valid_q ? out_ready_i : 1'b1;
    last       = (len_q == '0) || ((LEN_W'(idx_q) + LEN_W'(1)) == len_q);

    unique case (state_q)
      S_IDLE: begin
        stop_d  = 1'b0;
        prog_we = sel_wr_en_i && ({1'b0, sel_wr_addr_i} < (ADDR_W + 1)'(SEL_DEPTH));
        if (start_i) begin
          start_take = 1'b1;
          state_d    = S_FILL;
          need_d     = STR_W'(NUMBER_INPUT_MUX);
          window_d   = '0;
          idx_d      = '0;
          len_d      = ({1'b0, sel_len_i} > (LEN_W + 1)'(SEL_DEPTH)) ? LEN_W'(SEL_DEPTH) : sel_len_i;
          if (stride_i == '0)
            stride_d = STR_W'(1);
          else if ({1'b0, stride_i} > (STR_W + 1)'(NUMBER_INPUT_MUX))
            stride_d = STR_W'(NUMBER_INPUT_MUX);
          else
            stride_d = stride_i;
        end
      end
      S_FILL: begin
        if (stop_any) begin
          state_d = S_IDLE;
          stop_d  = 1'b0;
          need_d  = '0;
        end else if (data_valid_i && data_ready_q) begin
          window_d = {window_q[NUMBER_INPUT_MUX-2:0], data_i};
          need_d   = need_q - STR_W'(1);
          if (need_q == STR_W'(1)) begin
            state_d = S_PLAY;
            idx_d   = '0;
          end
        end
      end
      S_PLAY: begin
        stop_d = stop_any;
        if (step) begin
          if (last) begin
            finish = 1'b1;
            idx_d  = '0;
            if (stop_any) begin
              state_d = S_IDLE;
              stop_d  = 1'b0;
              need_d  = '0;
            end else begin
              state_d = S_FILL;
              need_d  = stride_q;
            end
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs, derived from the next state and next program index.
  always_comb begin
    logic [SEL_WIDTH_MUX-1:0] code;
    logic                     oor;
    logic                     emit;
    code         = prog_mem[idx_d];
    oor          = ({1'b0, code} > CW'(NUMBER_INPUT_MUX));
    emit         = 1'b0;
    data_ready_d = (state_d == S_FILL);
    play_done_d  = finish;
    sel_valid_d  = 1'b0;
    sel_mux_d    = '0;
    if (state_d == S_PLAY && len_d != '0) begin
`ifdef MUX_FEEDER_ZERO_SKIP_EN
      emit = (code != '0);
`else
      emit = 1'b1;
`endif
      sel_valid_d = emit;
      sel_mux_d   = oor ? '0 : code;
    end
    sel_err_d = start_take ? 1'b0 : (sel_err_q | (emit & oor));
  end

  assign window_o     = window_q;
  assign sel_mux_o    = sel_mux_q;
  assign sel_valid_o  = sel_valid_q;
  assign data_ready_o = data_ready_q;
  assign play_done_o  = play_done_q;
  assign sel_err_o    = sel_err_q;

endmodule

// File: tb/tb_mux_window_feeder.sv
module tb_mux_window_feeder;

  localparam int unsigned N   = 8;
  localparam int unsigned SW  = 4;
  localparam int unsigned W   = 16;
`ifdef MUX_FEEDER_ZERO_SKIP_EN
  localparam logic [31:0] EXP_ZV    = 32'd0;
  localparam logic [31:0] EXP_NVAL  = 32'd1;
`else
  localparam logic [31:0] EXP_ZV    = 32'd1;
  localparam logic [31:0] EXP_NVAL  = 32'd3;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    sel_wr_en;
  logic [3:0]              sel_wr_addr;
  logic [SW-1:0]           sel_wr_data;
  logic                    start;
  logic                    stop;
  logic [4:0]              sel_len;
  logic [3:0]              stride;
  logic                    data_valid;
  logic signed [W-1:0]     data;
  logic                    data_ready;
  logic [N-1:0][W-1:0]     window;
  logic [SW-1:0]           sel_mux;
  logic                    sel_valid;
  logic                    out_ready;
  logic                    play_done;
  logic                    sel_err;

  int n_checks = 0;
  int n_errors = 0;

  mux_window_feeder #(
    .I_WIDTH(8), .F_WIDTH(8), .NUMBER_INPUT_MUX(N), .SEL_WIDTH_MUX(SW), .SEL_DEPTH(16)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .sel_wr_en_i(sel_wr_en), .sel_wr_addr_i(sel_wr_addr), .sel_wr_data_i(sel_wr_data),
    .start_i(start), .stop_i(stop), .sel_len_i(sel_len), .stride_i(stride),
    .data_valid_i(data_valid), .data_i(data), .data_ready_o(data_ready),
    .window_o(window), .sel_mux_o(sel_mux), .sel_valid_o(sel_valid),
    .out_ready_i(out_ready), .play_done_o(play_done), .sel_err_o(sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int code);
    sel_wr_en   = 1'b1;
    sel_wr_addr = 4'(addr);
    sel_wr_data = SW'(code);
    tick();
    sel_wr_en   = 1'b0;
  endtask

  task automatic stream(input int first, input int count);
    for (int k = 0; k < count; k++) begin
      data_valid = 1'b1;
      data       = W'(first + k);
      tick();
    end
    data_valid = 1'b0;
  endtask

  initial begin
    int nv;
    int n2;
    int nd;
    rst_n = 1'b0; sel_wr_en = 1'b0; sel_wr_addr = '0; sel_wr_data = '0;
    start = 1'b0; stop = 1'b0; sel_len = '0; stride = '0;
    data_valid = 1'b0; data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_window0", 32'(window[0]), 32'd0);
    chk("rst_window7", 32'(window[7]), 32'd0);
    chk("rst_sel_valid", 32'(sel_valid), 32'd0);
    chk("rst_sel_mux", 32'(sel_mux), 32'd0);
    chk("rst_data_ready", 32'(data_ready), 32'd0);
    chk("rst_play_done", 32'(play_done), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Program {1,3,0,8}, len 4, stride 2.
    wr(0, 1); wr(1, 3); wr(2, 0); wr(3, 8);
    sel_len = 5'd4; stride = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("fill_ready", 32'(data_ready), 32'd1);
    chk("fill_no_valid", 32'(sel_valid), 32'd0);
    stream(1, 8);
    chk("p1_valid", 32'(sel_valid), 32'd1);
    chk("p1_code0", 32'(sel_mux), 32'd1);
    chk("p1_ready_low", 32'(data_ready), 32'd0);
    chk("p1_w0", 32'(window[0]), 32'd8);
    chk("p1_w7", 32'(window[7]), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("p1_code1", 32'(sel_mux), 32'd3);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_code", 32'(sel_mux), 32'd3);
      chk("stall_valid", 32'(sel_valid), 32'd1);
      chk("stall_w0", 32'(window[0]), 32'd8);
    end
    out_ready = 1'b1;
    tick();
    chk("p1_code2", 32'(sel_mux), 32'd0);
    chk("p1_code2_valid", 32'(sel_valid), EXP_ZV);
    tick();
    chk("p1_code3", 32'(sel_mux), 32'd8);
    chk("p1_code3_valid", 32'(sel_valid), 32'd1);
    tick();
    chk("p1_done", 32'(play_done), 32'd1);
    chk("p1_done_valid", 32'(sel_valid), 32'd0);
    chk("p1_refill_ready", 32'(data_ready), 32'd1);
    out_ready = 1'b0;

    // Stride 2: samples 9 and 10 form the next window.
    data_valid = 1'b1; data = W'(9);
    tick();
    chk("done_pulse_end", 32'(play_done), 32'd0);
    data = W'(10);
    tick();
    data_valid = 1'b0;
    chk("p2_valid", 32'(sel_valid), 32'd1);
    chk("p2_code0", 32'(sel_mux), 32'd1);
    chk("p2_w0", 32'(window[0]), 32'd10);
    chk("p2_w1", 32'(window[1]), 32'd9);
    chk("p2_w7", 32'(window[7]), 32'd3);

    // Stop mid-PLAY: window completes, then IDLE.
    stop = 1'b1; out_ready = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_code1", 32'(sel_mux), 32'd3);
    chk("stop_valid1", 32'(sel_valid), 32'd1);
    tick();
    tick();
    chk("stop_code3", 32'(sel_mux), 32'd8);
    tick();
    chk("stop_done", 32'(play_done), 32'd1);
    chk("stop_idle_ready", 32'(data_ready), 32'd0);
    chk("stop_idle_valid", 32'(sel_valid), 32'd0);
    out_ready = 1'b0;
    tick();
    chk("idle_hold_ready", 32'(data_ready), 32'd0);

    // Out-of-range code 9.
    wr(0, 9);
    sel_len = 5'd1; stride = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    chk("oor_err_before", 32'(sel_err), 32'd0);
    stream(11, 8);
    chk("oor_valid", 32'(sel_valid), 32'd1);
    chk("oor_code_forced", 32'(sel_mux), 32'd0);
    chk("oor_err_set", 32'(sel_err), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("oor_done", 32'(play_done), 32'd1);
    chk("oor_err_sticky", 32'(sel_err), 32'd1);
    chk("oor_fill", 32'(data_ready), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("fill_stop_idle", 32'(data_ready), 32'd0);
    chk("oor_err_idle", 32'(sel_err), 32'd1);

    // len 0, stride 3; start clears the error flag.
    wr(0, 2);
    sel_len = 5'd0; stride = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_err_clr", 32'(sel_err), 32'd0);
    chk("len0_fill", 32'(data_ready), 32'd1);
    stream(20, 8);
    chk("len0_no_valid", 32'(sel_valid), 32'd0);
    chk("len0_play_ready", 32'(data_ready), 32'd0);
    chk("len0_no_done_yet", 32'(play_done), 32'd0);
    tick();
    chk("len0_done", 32'(play_done), 32'd1);
    chk("len0_refill", 32'(data_ready), 32'd1);
    chk("len0_done_valid", 32'(sel_valid), 32'd0);
    stream(30, 2);
    chk("len0_need_left", 32'(data_ready), 32'd1);
    stream(32, 1);
    chk("len0_stride_full", 32'(data_ready), 32'd0);
    chk("len0_w0", 32'(window[0]), 32'd32);
    chk("len0_p2_valid", 32'(sel_valid), 32'd0);
    tick();
    chk("len0_done2", 32'(play_done), 32'd1);

    // Asynchronous reset during FILL.
    data_valid = 1'b1; data = W'(16'h0077);
    tick();
    data_valid = 1'b0;
    chk("pre_rst_w0", 32'(window[0]), 32'h77);
    chk("pre_rst_ready", 32'(data_ready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_w0", 32'(window[0]), 32'd0);
    chk("arst_w1", 32'(window[1]), 32'd0);
    chk("arst_ready", 32'(data_ready), 32'd0);
    chk("arst_done", 32'(play_done), 32'd0);
    chk("arst_valid", 32'(sel_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(data_ready), 32'd0);

    // Program {0,2,0}: zero-code handling.
    wr(0, 0); wr(1, 2); wr(2, 0);
    sel_len = 5'd3; stride = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    stream(40, 8);
    out_ready = 1'b1;
    nv = 0; n2 = 0; nd = 0;
    for (int i = 0; i < 6; i++) begin
      if (sel_valid) nv++;
      if (sel_valid && sel_mux == SW'(2)) n2++;
      if (play_done) nd++;
      tick();
    end
    out_ready = 1'b0;
    chk("zs_valid_count", 32'(nv), EXP_NVAL);
    chk("zs_code2_count", 32'(n2), 32'd1);
    chk("zs_done_count", 32'(nd), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
